cnn_argmax_classifier: RTL and testbench
========================================

# cnn_argmax_classifier

Output stage of the CNN, directly downstream of the fully-connected layer. It captures the six signed class scores from one fully-connected result pulse and adds a per-class programmable bias with saturation. It then scans the scores sequentially to find the winning class and presents the class index and score on a valid/ready output port. Frames that arrive while a previous result is still being processed or is awaiting acceptance are dropped and counted.

## Interface
Parameters:
- DW, 24, width of scores, biases and result score (signed two's complement)
- CW, 8, width of the dropped-frame counter

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  asynchronous, active-high reset; all registers, bias file and outputs clear immediately on assertion
- DIN_VALID  in  1  one-cycle pulse: DIN1..DIN6 carry a new score vector this cycle
- DIN1..DIN6  in  DW each  signed class scores 0..5 (DIN1 = class 0)
- BIAS_WEN  in  1  bias write strobe
- BIAS_REN  in  1  bias read strobe
- BIAS_ADDR  in  3  bias index 0..5; 6 and 7 are unmapped
- BIAS_WDATA  in  DW  signed bias write data
- BIAS_RDATA  out  DW  registered bias read data
- OUT_VALID  out  1  result available
- OUT_READY  in  1  consumer accepts result
- CLASS_IDX  out  3  winning class 0..5
- CLASS_SCORE  out  DW  biased score of winning class
- BUSY  out  1  high whenever state ≠ IDLE
- DROP_CNT  out  CW  saturating count of dropped frames

## Operation
- Reset values: OUT_VALID=0, CLASS_IDX=0, CLASS_SCORE=0, BIAS_RDATA=0, BUSY=0, DROP_CNT=0, all six biases=0, state=IDLE.
- Bias file: six DW-bit registers.
  - BIAS_WEN with addr 0..5 writes on the clock edge; addr 6/7 writes are ignored.
  - BIAS_REN loads BIAS_RDATA on the next edge; addr 6/7 returns 0.
  - When BIAS_REN is low, BIAS_RDATA holds its value.
  - A write and a read to the same address in the same cycle returns the old value.
- Biased score: s[i] = sat(DIN(i+1) + bias[i]), computed at DW+1 bits and clamped to [−2^(DW−1), 2^(DW−1)−1]. For DW=24 the range is [−8388608, 8388607].
- FSM states: IDLE, SCAN, OUT.
  - IDLE, with DIN_VALID=1:
    - Latch s[0..5] into the score registers.
    - best_score←s[0], best_idx←0, cnt←1.
    - Go to SCAN.
  - SCAN, one comparison per cycle:
    - If score[cnt] > best_score, meaning strictly greater in a signed comparison, update best_score and best_idx.
    - cnt increments each cycle.
    - On the cycle with cnt=5: load CLASS_IDX and CLASS_SCORE with the final best, set OUT_VALID←1 and go to OUT.
  - OUT: hold OUT_VALID, CLASS_IDX and CLASS_SCORE stable until OUT_READY=1 is sampled. On that edge OUT_VALID←0 and go to IDLE. CLASS_IDX and CLASS_SCORE keep their last values after the handshake.
- Ties: the lowest index wins, because only a strict greater-than replaces the current best.
- Drops: a DIN_VALID sampled in SCAN or OUT discards the frame and increments DROP_CNT, which saturates at 2^CW−1. This includes the OUT handshake edge; a new frame is accepted only in IDLE.
- Bias timing: the bias value is applied only at the capture edge. A bias write during SCAN or OUT affects the next frame. A write coinciding with the capture edge uses the old bias for that frame.

## Timing
- DIN_VALID sampled at edge E0 → SCAN comparisons at E1..E5 → OUT_VALID high from E5. Latency is 5 cycles from the sampled edge to OUT_VALID. The minimum frame interval is 7 cycles when OUT_READY is already high.
- OUT_READY may be held high permanently. OUT_VALID is then high for exactly one cycle.
- BUSY is asserted from E0 through the handshake edge.
- RST asserted mid-SCAN or mid-OUT: OUT_VALID drops asynchronously, the bias file and DROP_CNT clear, and the first DIN_VALID after deassertion is accepted normally.

## Test plan
- Basic argmax: biases 0, DIN1..6 = 10, −5, 300, 7, 299, 0, OUT_READY=1 → CLASS_IDX=2, CLASS_SCORE=300, OUT_VALID visible 5 cycles after the sampled edge, for exactly one cycle.
- Ties and negatives: DIN1..6 = −100, −3, −3, −50, −3, −8388608 → CLASS_IDX=1, CLASS_SCORE=−3.
- Bias and saturation:
  - Step 1: write bias[5]=8388000, DIN6=1000, others 0 → CLASS_IDX=5, CLASS_SCORE=8388607.
  - Step 2: write bias[0]=−1, DIN1=−8388608 → s[0] clamps to −8388608.
  - Step 3: read back bias[5] → BIAS_RDATA=8388000 one cycle later.
  - Step 4: read addr 7 → BIAS_RDATA=0.
- Backpressure and drop: hold OUT_READY=0 and send a second DIN_VALID during SCAN and a third during OUT → OUT_VALID and data stay stable, DROP_CNT=2. Then raise OUT_READY → OUT_VALID falls and the next DIN_VALID is accepted.
- Drop saturation (CW=8): 300 drops while OUT is stalled → DROP_CNT=255.
- Reset mid-scan: assert RST 3 cycles after DIN_VALID → OUT_VALID=0, BUSY=0 and DROP_CNT=0 immediately. After release, a new frame produces the correct result with all biases equal to 0.

Source files
------------

// File: rtl/cnn_argmax_classifier.sv
// cnn_argmax_classifier: output stage after the fully-connected layer.
// Captures six signed class scores, adds a saturating per-class bias,
// scans them one per cycle for the winner (lowest index on ties) and
// offers the result on a valid/ready port. Frames arriving while busy
// are dropped and counted in a saturating counter.
module cnn_argmax_classifier #(
    parameter int DW = 24,
    parameter int CW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          DIN_VALID,
    input  logic [DW-1:0] DIN1,
    input  logic [DW-1:0] DIN2,
    input  logic [DW-1:0] DIN3,
    input  logic [DW-1:0] DIN4,
    input  logic [DW-1:0] DIN5,
    input  logic [DW-1:0] DIN6,
    input  logic          BIAS_WEN,
    input  logic          BIAS_REN,
    input  logic [2:0]    BIAS_ADDR,
    input  logic [DW-1:0] BIAS_WDATA,
    output logic [DW-1:0] BIAS_RDATA,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [2:0]    CLASS_IDX,
    output logic [DW-1:0] CLASS_SCORE,
    output logic          BUSY,
    output logic [CW-1:0] DROP_CNT
);

    typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

    localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

    state_t state, next_state;

    logic signed [DW-1:0] bias    [6];
    logic signed [DW-1:0] score   [6];
    logic signed [DW-1:0] din_vec [6];
    logic signed [DW-1:0] biased  [6];
    logic signed [DW-1:0] best_score;
    logic [2:0]           best_idx;
    logic [2:0]           cnt;

    logic signed [DW-1:0] cand;
    logic signed [DW-1:0] next_best_score;
    logic [2:0]           next_best_idx;
    logic                 capture;
    logic                 drop;
    logic                 scan_done;
    logic                 handshake;

    // Add at DW+1 bits, clamp to the signed DW-bit range on overflow.
    function automatic logic signed [DW-1:0] sat_add(
        input logic signed [DW-1:0] a,
        input logic signed [DW-1:0] b
    );
        logic signed [DW:0] sum;
        sum = {a[DW-1], a} + {b[DW-1], b};
        if (sum[DW] != sum[DW-1])
            return sum[DW] ? SMIN : SMAX;
        return sum[DW-1:0];
    endfunction

    // Bias every incoming score; only consumed on the capture edge.
    always_comb begin
        din_vec[0] = DIN1;
        din_vec[1] = DIN2;
        din_vec[2] = DIN3;
        din_vec[3] = DIN4;
        din_vec[4] = DIN5;
        din_vec[5] = DIN6;
        for (int i = 0; i < 6; i++)
            biased[i] = sat_add(din_vec[i], bias[i]);
    end

    // One scan step: strict greater-than keeps the lowest index on ties.
    always_comb begin
        cand            = score[cnt];
        next_best_score = best_score;
        next_best_idx   = best_idx;
        if (cand > best_score) begin
            next_best_score = cand;
            next_best_idx   = cnt;
        end
    end

    assign capture   = DIN_VALID && (state == IDLE);
    assign drop      = DIN_VALID && (state != IDLE);
    assign scan_done = (state == SCAN) && (cnt == 3'd5);
    assign handshake = (state == OUT) && OUT_READY;
    assign BUSY      = (state != IDLE);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path through the case leaves next_state
        // unassigned, which would otherwise infer a latch.
        next_state = state;
        case (state)
            IDLE:    if (DIN_VALID) next_state = SCAN;
            SCAN:    if (cnt == 3'd5) next_state = OUT;
            OUT:     if (OUT_READY) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Score capture, sequential scan and result register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 6; i++) score[i] <= '0;
            best_score  <= '0;
            best_idx    <= '0;
            cnt         <= '0;
            OUT_VALID   <= 1'b0;
            CLASS_IDX   <= '0;
            CLASS_SCORE <= '0;
        end else begin
            if (capture) begin
                for (int i = 0; i < 6; i++) score[i] <= biased[i];
                best_score <= biased[0];
                best_idx   <= 3'd0;
                cnt        <= 3'd1;
            end else if (state == SCAN) begin
                best_score <= next_best_score;
                best_idx   <= next_best_idx;
                cnt        <= cnt + 3'd1;
            end
            if (scan_done) begin
                CLASS_IDX   <= next_best_idx;
                CLASS_SCORE <= next_best_score;
                OUT_VALID   <= 1'b1;
            end else if (handshake) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

    // Bias file writes; unmapped addresses are ignored.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: the bias file is six plain flops rather than a RAM macro, so it
        // can take the asynchronous clear like any other register.
        if (RST) begin
            for (int i = 0; i < 6; i++) bias[i] <= '0;
        end else if (BIAS_WEN && (BIAS_ADDR < 3'd6)) begin
            bias[BIAS_ADDR] <= BIAS_WDATA;
        end
    end

    // Registered bias read; returns pre-write data on a same-cycle write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            BIAS_RDATA <= '0;
        else if (BIAS_REN)
            BIAS_RDATA <= (BIAS_ADDR < 3'd6) ? bias[BIAS_ADDR] : '0;
    end

    // Saturating dropped-frame counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            DROP_CNT <= '0;
        else if (drop && (DROP_CNT != {CW{1'b1}}))
            DROP_CNT <= DROP_CNT + 1'b1;
    end

endmodule

// File: tb/tb_cnn_argmax_classifier.sv
// Testbench for cnn_argmax_classifier: directed cases plus randomized
// frames; expected results come from an arithmetic argmax model and are
// checked by a monitor that pops a scoreboard queue on each handshake.
module tb_cnn_argmax_classifier;

    localparam int DW = 24;
    localparam int CW = 8;
    localparam longint MAXV = (64'sd1 <<< (DW-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (DW-1));

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic                 DIN_VALID = 1'b0;
    logic signed [DW-1:0] din [6];
    logic                 BIAS_WEN = 1'b0;
    logic                 BIAS_REN = 1'b0;
    logic [2:0]           BIAS_ADDR = '0;
    logic [DW-1:0]        BIAS_WDATA = '0;
    logic [DW-1:0]        BIAS_RDATA;
    logic                 OUT_VALID;
    logic                 OUT_READY = 1'b0;
    logic [2:0]           CLASS_IDX;
    logic [DW-1:0]        CLASS_SCORE;
    logic                 BUSY;
    logic [CW-1:0]        DROP_CNT;

    cnn_argmax_classifier #(.DW(DW), .CW(CW)) dut (
        .CLK(CLK), .RST(RST), .DIN_VALID(DIN_VALID),
        .DIN1(din[0]), .DIN2(din[1]), .DIN3(din[2]),
        .DIN4(din[3]), .DIN5(din[4]), .DIN6(din[5]),
        .BIAS_WEN(BIAS_WEN), .BIAS_REN(BIAS_REN), .BIAS_ADDR(BIAS_ADDR),
        .BIAS_WDATA(BIAS_WDATA), .BIAS_RDATA(BIAS_RDATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .CLASS_IDX(CLASS_IDX), .CLASS_SCORE(CLASS_SCORE),
        .BUSY(BUSY), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int     idx;
        longint score;
    } exp_t;

    exp_t   sb [$];
    exp_t   last_push;
    longint bias_m [6];
    longint exp_drop;
    int     n_cmp = 0;
    int     n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    // Reference: biased scores, then first index holding the maximum.
    function automatic exp_t model_result();
        exp_t   r;
        longint s [6];
        for (int i = 0; i < 6; i++) s[i] = sat(longint'(din[i]) + bias_m[i]);
        r.idx = 0;
        for (int i = 1; i < 6; i++) if (s[i] > s[r.idx]) r.idx = i;
        r.score = s[r.idx];
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_din(input longint a0, input longint a1, input longint a2,
                           input longint a3, input longint a4, input longint a5);
        din[0] = a0[DW-1:0]; din[1] = a1[DW-1:0]; din[2] = a2[DW-1:0];
        din[3] = a3[DW-1:0]; din[4] = a4[DW-1:0]; din[5] = a5[DW-1:0];
    endtask

    // One DIN_VALID pulse; the model decides up front whether it is kept.
    task automatic send(input bit accept);
        DIN_VALID = 1'b1;
        if (accept) begin
            last_push = model_result();
            sb.push_back(last_push);
        end else if (exp_drop < 255) begin
            exp_drop++;
        end
        tick();
        DIN_VALID = 1'b0;
    endtask

    task automatic bias_write(input int addr, input longint data);
        BIAS_WEN   = 1'b1;
        BIAS_ADDR  = addr[2:0];
        BIAS_WDATA = data[DW-1:0];
        tick();
        BIAS_WEN = 1'b0;
        if (addr < 6) bias_m[addr] = sat(data);
    endtask

    task automatic bias_read_check(input int addr, input longint exp, input string name);
        BIAS_REN  = 1'b1;
        BIAS_ADDR = addr[2:0];
        tick();
        BIAS_REN = 1'b0;
        check(name, longint'($signed(BIAS_RDATA)), exp);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        for (k = 0; k < budget && BUSY; k++) tick();
        if (BUSY) check("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_idle_rand(input int budget);
        int k;
        for (k = 0; k < budget && BUSY; k++) begin
            OUT_READY = 1'($urandom_range(0, 1));
            tick();
        end
        if (BUSY) check("wait_idle_rand_timeout", 1, 0);
    endtask

    task automatic wait_out_valid(input int budget);
        int k;
        for (k = 0; k < budget && !OUT_VALID; k++) tick();
        if (!OUT_VALID) check("wait_valid_timeout", 1, 0);
    endtask

    function automatic longint rnd_val();
        case ($urandom_range(0, 3))
            0:       return longint'($urandom_range(0, (1 << DW) - 1)) + MINV;
            1:       return longint'($urandom_range(0, 16)) - 8;
            2:       return $urandom_range(0, 1) ? MAXV : MINV;
            default: return longint'($urandom_range(0, 2000)) - 1000;
        endcase
    endfunction

    // Monitor: a handshake is pending when valid and ready are both high
    // half a cycle before the edge; pop and compare exactly once per transfer.
    always @(negedge CLK) begin
        if (!RST && OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("class_idx", longint'(CLASS_IDX), longint'(e.idx));
                check("class_score", longint'($signed(CLASS_SCORE)), e.score);
            end
        end
    end

    initial begin
        for (int i = 0; i < 6; i++) bias_m[i] = 0;
        exp_drop = 0;
        set_din(0, 0, 0, 0, 0, 0);

        // Reset values
        #3;
        check("rst_out_valid", longint'(OUT_VALID), 0);
        check("rst_class_idx", longint'(CLASS_IDX), 0);
        check("rst_class_score", longint'(CLASS_SCORE), 0);
        check("rst_bias_rdata", longint'(BIAS_RDATA), 0);
        check("rst_busy", longint'(BUSY), 0);
        check("rst_drop_cnt", longint'(DROP_CNT), 0);
        tick();
        RST = 1'b0;
        OUT_READY = 1'b1;
        tick();

        // Basic argmax with latency and one-cycle valid
        set_din(10, -5, 300, 7, 299, 0);
        send(1);
        check("busy_after_capture", longint'(BUSY), 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("valid_before_latency", longint'(OUT_VALID), 0);
        end
        tick();
        check("valid_at_latency", longint'(OUT_VALID), 1);
        tick();
        check("valid_one_cycle", longint'(OUT_VALID), 0);
        check("busy_after_handshake", longint'(BUSY), 0);

        // Ties and negatives
        set_din(-100, -3, -3, -50, -3, MINV);
        send(1);
        wait_idle(30);

        // Bias saturation, readback, unmapped read, same-cycle write/read
        bias_write(5, 8388000);
        set_din(0, 0, 0, 0, 0, 1000);
        send(1);
        wait_idle(30);
        bias_read_check(5, 8388000, "bias5_readback");
        tick();
        check("bias_rdata_hold", longint'($signed(BIAS_RDATA)), 8388000);
        bias_read_check(7, 0, "bias_addr7_read");
        BIAS_WEN = 1'b1; BIAS_REN = 1'b1; BIAS_ADDR = 3'd5; BIAS_WDATA = 24'd123;
        tick();
        BIAS_WEN = 1'b0; BIAS_REN = 1'b0;
        check("same_cycle_rw_old", longint'($signed(BIAS_RDATA)), 8388000);
        bias_m[5] = 123;
        bias_read_check(5, 123, "bias5_new_value");
        bias_write(6, 555);
        bias_read_check(6, 0, "bias_addr6_read");
        bias_write(5, 0);
        bias_write(0, -1);
        set_din(MINV, MINV, MINV, MINV, MINV, MINV);
        send(1);
        wait_idle(30);

        // Backpressure with drops in SCAN and OUT
        OUT_READY = 1'b0;
        set_din(1, 2, 3, 40, 5, 6);
        send(1);
        tick();
        set_din(999, 0, 0, 0, 0, 0);
        send(0);
        wait_out_valid(20);
        send(0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", longint'(OUT_VALID), 1);
            check("stall_idx", longint'(CLASS_IDX), longint'(last_push.idx));
            check("stall_score", longint'($signed(CLASS_SCORE)), last_push.score);
        end
        check("drop_cnt_two", longint'(DROP_CNT), 2);
        OUT_READY = 1'b1;
        tick();
        check("valid_after_ready", longint'(OUT_VALID), 0);
        check("idx_kept_after_hs", longint'(CLASS_IDX), longint'(last_push.idx));
        set_din(7, 7, 8, 8, -1, 0);
        send(1);
        wait_idle(30);

        // Drop counter saturation
        OUT_READY = 1'b0;
        send(1);
        for (int k = 0; k < 300; k++) send(0);
        check("drop_cnt_saturated", longint'(DROP_CNT), exp_drop);
        check("drop_cnt_is_255", longint'(DROP_CNT), 255);
        OUT_READY = 1'b1;
        wait_idle(30);

        // Reset mid-scan: frame discarded, state and bias file cleared
        set_din(5, 5, 5, 5, 5, 5);
        DIN_VALID = 1'b1;
        tick();
        DIN_VALID = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        #1;
        check("midrst_out_valid", longint'(OUT_VALID), 0);
        check("midrst_busy", longint'(BUSY), 0);
        check("midrst_drop_cnt", longint'(DROP_CNT), 0);
        for (int i = 0; i < 6; i++) bias_m[i] = 0;
        exp_drop = 0;
        tick();
        RST = 1'b0;
        tick();
        send(1);
        wait_idle(30);

        // Randomized frames: bias writes idle / at capture / during scan,
        // random backpressure and occasional drops.
        for (int f = 0; f < 60; f++) begin
            int     wa;
            longint wd;
            if ($urandom_range(0, 2) == 0) bias_write($urandom_range(0, 7), rnd_val());
            for (int i = 0; i < 6; i++) begin
                longint v;
                v = rnd_val();
                din[i] = v[DW-1:0];
            end
            wa = $urandom_range(0, 7);
            wd = rnd_val();
            if ($urandom_range(0, 3) == 0) begin
                BIAS_WEN = 1'b1; BIAS_ADDR = wa[2:0]; BIAS_WDATA = wd[DW-1:0];
                send(1);
                BIAS_WEN = 1'b0;
                if (wa < 6) bias_m[wa] = wd;
            end else begin
                send(1);
            end
            if ($urandom_range(0, 3) == 0) send(0);
            if ($urandom_range(0, 3) == 0) bias_write($urandom_range(0, 5), rnd_val());
            wait_idle_rand(400);
        end
        check("rand_drop_cnt", longint'(DROP_CNT), exp_drop);
        OUT_READY = 1'b1;
        tick();
        check("scoreboard_empty", longint'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
